// File: rtl/lc3_mem_pkg.sv
// Shared types and device register addresses for the LC3 memory controller.
package lc3_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous backing store; read data is registered and held between reads.
module lc3_mem_array #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AW         = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One access per enabled cycle: write stores, read updates rdata.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC3 memory controller: request/ready handshake with wait states, backing
// store and memory-mapped keyboard/display registers.
// Optional: define LC3_MEM_ERR_EN to add the sticky mem_err output.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DEPTH         = 4096,
    parameter int unsigned WAIT_STATES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_en,
    input  logic                     memwe,
    input  logic [ADDRESS_WIDTH-1:0] mar,
    input  logic [DATA_W-1:0]        mdr,
    output logic [DATA_W-1:0]        memOut,
    output logic                     mem_rdy,
    input  logic                     kbd_valid,
    input  logic [7:0]               kbd_data,
    output logic                     disp_valid,
    output logic [7:0]               disp_data,
    input  logic                     disp_ready
`ifdef LC3_MEM_ERR_EN
    ,
    output logic                     mem_err
`endif
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t            state_q, state_d;
    logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  accept_c, done_c;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic                     we_q;

    logic                  in_ram_c;
    logic                  is_kbsr_c, is_kbdr_c, is_dsr_c, is_ddr_c;
    logic [DATA_W-1:0]     dev_rd_c;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  sel_ram_q;
    logic [DATA_W-1:0]     dev_rdata_q;

    logic                  kbd_full_q;
    logic [7:0]            kbd_char_q;
    logic                  kbdr_rd_c, ddr_wr_c, ddr_acc_c;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, complete in DONE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        accept_c   = 1'b0;
        done_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    accept_c   = 1'b1;
                    wait_cnt_d = WCNT_W'(WAIT_STATES);
                    state_d    = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - WCNT_W'(1);
                if (wait_cnt_q == WCNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch; decode and access use only the latched copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (accept_c) begin
            addr_q  <= mar;
            wdata_q <= mdr;
            we_q    <= memwe;
        end
    end

    assign in_ram_c = (32'(addr_q) < DEPTH);

    // Device registers exist only in the full 16-bit address space; RAM wins on overlap.
    if (ADDRESS_WIDTH == 16) begin : g_dev
        assign is_kbsr_c = !in_ram_c && (16'(addr_q) == KBSR_ADDR);
        assign is_kbdr_c = !in_ram_c && (16'(addr_q) == KBDR_ADDR);
        assign is_dsr_c  = !in_ram_c && (16'(addr_q) == DSR_ADDR);
        assign is_ddr_c  = !in_ram_c && (16'(addr_q) == DDR_ADDR);
    end else begin : g_nodev
        assign is_kbsr_c = 1'b0;
        assign is_kbdr_c = 1'b0;
        assign is_dsr_c  = 1'b0;
        assign is_ddr_c  = 1'b0;
    end

    lc3_mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_W),
        .AW         (RAM_AW)
    ) u_array (
        .clk   (clk),
        .en    (done_c && in_ram_c),
        .we    (we_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Device read value; DDR and unmapped addresses read as zero.
    always_comb begin
        dev_rd_c = '0;
        if (is_kbsr_c) begin
            dev_rd_c = {kbd_full_q, 15'b0};
        end else if (is_kbdr_c) begin
            dev_rd_c = {8'h00, kbd_char_q};
        end else if (is_dsr_c) begin
            dev_rd_c = {~disp_valid, 15'b0};
        end
    end

    // Completion pulse and read-result capture; writes leave memOut untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rdy     <= 1'b0;
            sel_ram_q   <= 1'b0;
            dev_rdata_q <= '0;
        end else begin
            mem_rdy <= done_c;
            if (done_c && !we_q) begin
                sel_ram_q   <= in_ram_c;
                dev_rdata_q <= in_ram_c ? '0 : dev_rd_c;
            end
        end
    end

    assign memOut = sel_ram_q ? ram_rdata : dev_rdata_q;

    assign kbdr_rd_c = done_c && !we_q && is_kbdr_c;
    assign ddr_wr_c  = done_c &&  we_q && is_ddr_c;
    assign ddr_acc_c = ddr_wr_c && (!disp_valid || disp_ready);

    // Keyboard: capture when empty, or when a KBDR read frees the slot this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_full_q <= 1'b0;
            kbd_char_q <= 8'h00;
        end else if (kbd_valid && (!kbd_full_q || kbdr_rd_c)) begin
            kbd_full_q <= 1'b1;
            kbd_char_q <= kbd_data;
        end else if (kbdr_rd_c) begin
            kbd_full_q <= 1'b0;
        end
    end

    // Display: load on an accepted DDR write, release on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else if (ddr_acc_c) begin
            disp_valid <= 1'b1;
            disp_data  <= wdata_q[7:0];
        end else if (disp_valid && disp_ready) begin
            disp_valid <= 1'b0;
        end
    end

`ifdef LC3_MEM_ERR_EN
    logic mapped_c;
    logic ddr_drop_c;

    assign mapped_c   = in_ram_c || is_kbsr_c || is_kbdr_c || is_dsr_c || is_ddr_c;
    assign ddr_drop_c = ddr_wr_c && disp_valid && !disp_ready;

    // Sticky error on unmapped access or dropped display write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err <= 1'b0;
        end else if (done_c && (!mapped_c || ddr_drop_c)) begin
            mem_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl with a behavioural memory/device model.
module tb_lc3_mem_ctrl;

    localparam int WS    = 2;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_en = 1'b0;
    logic        memwe = 1'b0;
    logic [15:0] mar = '0;
    logic [15:0] mdr = '0;
    logic [15:0] memOut;
    logic        mem_rdy;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = '0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;
`ifdef LC3_MEM_ERR_EN
    logic        mem_err;
`endif

    lc3_mem_ctrl #(
        .ADDRESS_WIDTH (16),
        .DEPTH         (DEPTH),
        .WAIT_STATES   (WS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_en     (mem_en),
        .memwe      (memwe),
        .mar        (mar),
        .mdr        (mdr),
        .memOut     (memOut),
        .mem_rdy    (mem_rdy),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
`ifdef LC3_MEM_ERR_EN
        ,
        .mem_err    (mem_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state.
    logic [15:0] mem_m [0:DEPTH-1];
    bit          kbd_full_m = 0;
    logic [7:0]  kbd_char_m = 8'h00;
    bit          dv_m = 0;
    logic [7:0]  dd_m = 8'h00;
    logic [15:0] last_rd_m = 16'h0000;
    bit          err_m = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one access to the model; returns what memOut should show afterwards.
    task automatic model_access(input bit we, input logic [15:0] a, input logic [15:0] d,
                                input bit inj_kbd, input logic [7:0] kc, input bit inj_rdy,
                                output logic [15:0] exp_out);
        logic [15:0] r;
        bit ddr_taken;
        ddr_taken = 0;
        if (!we) begin
            if (int'(a) < DEPTH)        r = mem_m[a];
            else if (a == 16'hFE00)     r = {kbd_full_m, 15'b0};
            else if (a == 16'hFE02) begin
                r = {8'h00, kbd_char_m};
                kbd_full_m = 0;
            end
            else if (a == 16'hFE04)     r = {!dv_m, 15'b0};
            else if (a == 16'hFE06)     r = 16'h0000;
            else begin
                r = 16'h0000;
                err_m = 1;
            end
            last_rd_m = r;
        end else begin
            if (int'(a) < DEPTH) mem_m[a] = d;
            else if (a == 16'hFE06) begin
                if (!dv_m || inj_rdy) begin
                    dv_m = 1;
                    dd_m = d[7:0];
                    ddr_taken = 1;
                end else begin
                    err_m = 1;
                end
            end
            else if (a != 16'hFE00 && a != 16'hFE02 && a != 16'hFE04) err_m = 1;
        end
        if (inj_rdy && !ddr_taken) dv_m = 0;
        if (inj_kbd && !kbd_full_m) begin
            kbd_full_m = 1;
            kbd_char_m = kc;
        end
        exp_out = last_rd_m;
    endtask

    // One request through the DUT, optionally strobing keyboard/display-ready in its completion cycle.
    task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d,
                          input bit inj_kbd, input logic [7:0] kc, input bit inj_rdy,
                          input string tag);
        logic [15:0] exp_out;
        int  k;
        bit  seen;
        model_access(we, a, d, inj_kbd, kc, inj_rdy, exp_out);
        @(negedge clk);
        mem_en = 1'b1; memwe = we; mar = a; mdr = d;
        @(posedge clk);
        #1 mem_en = 1'b0; memwe = 1'b0;
        seen = 0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            kbd_valid  = 1'b0;
            disp_ready = 1'b0;
            if (k == WS + 1) begin
                if (inj_kbd) begin
                    kbd_valid = 1'b1;
                    kbd_data  = kc;
                end
                if (inj_rdy) disp_ready = 1'b1;
            end
            if (mem_rdy) seen = 1;
        end
        kbd_valid  = 1'b0;
        disp_ready = 1'b0;
        check({tag, " latency"}, 16'(k), 16'(WS + 2));
        check({tag, " memOut"}, memOut, exp_out);
        check({tag, " disp_valid"}, {15'b0, disp_valid}, {15'b0, dv_m});
        check({tag, " disp_data"}, {8'h00, disp_data}, {8'h00, dd_m});
`ifdef LC3_MEM_ERR_EN
        check({tag, " mem_err"}, {15'b0, mem_err}, {15'b0, err_m});
`endif
        @(negedge clk);
        check({tag, " rdy pulse"}, {15'b0, mem_rdy}, 16'h0000);
    endtask

    task automatic kbd_pulse(input logic [7:0] c);
        @(negedge clk);
        kbd_valid = 1'b1;
        kbd_data  = c;
        @(negedge clk);
        kbd_valid = 1'b0;
        if (!kbd_full_m) begin
            kbd_full_m = 1;
            kbd_char_m = c;
        end
    endtask

    task automatic model_reset();
        kbd_full_m = 0;
        kbd_char_m = 8'h00;
        dv_m       = 0;
        dd_m       = 8'h00;
        last_rd_m  = 16'h0000;
        err_m      = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " memOut"}, memOut, 16'h0000);
        check({tag, " mem_rdy"}, {15'b0, mem_rdy}, 16'h0000);
        check({tag, " disp_valid"}, {15'b0, disp_valid}, 16'h0000);
        check({tag, " disp_data"}, {8'h00, disp_data}, 16'h0000);
`ifdef LC3_MEM_ERR_EN
        check({tag, " mem_err"}, {15'b0, mem_err}, 16'h0000);
`endif
    endtask

    initial begin
        int pulses;
        int exp_pulses;
        int next_free;
        int sel;
        logic [15:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, 0, "kbsr_after_reset");
        access(0, 16'hFE02, 16'h0000, 0, 8'h00, 0, "kbdr_after_reset");

`ifdef LC3_MEM_ERR_EN
        // Unmapped read raises the sticky error
        access(0, 16'hC000, 16'h0000, 0, 8'h00, 0, "unmapped_rd");
`endif

        // Write/read latency
        access(1, 16'h0010, 16'hBEEF, 0, 8'h00, 0, "wr_0010");
        access(0, 16'h0010, 16'h0000, 0, 8'h00, 0, "rd_0010");
        access(1, 16'h0FFF, 16'h5A5A, 0, 8'h00, 0, "wr_top");
        access(0, 16'h0FFF, 16'h0000, 0, 8'h00, 0, "rd_top");

        // Back-to-back requests with mem_en held high
        for (int i = 0; i < 12; i++) access(1, 16'h0100 + 16'(i), 16'h0000, 0, 8'h00, 0, "pre_b2b");
        pulses = 0;
        exp_pulses = 0;
        next_free = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(mem_rdy);
            mem_en = 1'b1; memwe = 1'b1;
            mar = 16'h0100 + 16'(i);
            mdr = 16'hA000 + 16'(i);
            if (i >= next_free) begin
                mem_m[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
                exp_pulses++;
                next_free = i + WS + 2;
            end
            @(posedge clk);
        end
        #1 mem_en = 1'b0; memwe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulses += int'(mem_rdy);
        end
        check("b2b pulses", 16'(pulses), 16'(exp_pulses));
        for (int i = 0; i < 12; i++) access(0, 16'h0100 + 16'(i), 16'h0000, 0, 8'h00, 0, "rd_b2b");

        // Keyboard
        kbd_pulse(8'h41);
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, 0, "kbsr_full");
        kbd_pulse(8'h42);
        access(0, 16'hFE02, 16'h0000, 0, 8'h00, 0, "kbdr_41");
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, 0, "kbsr_empty");
        kbd_pulse(8'h55);
        access(0, 16'hFE02, 16'h0000, 1, 8'h66, 0, "kbdr_same_cycle");
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, 0, "kbsr_refilled");
        access(0, 16'hFE02, 16'h0000, 0, 8'h00, 0, "kbdr_66");

        // Display
        access(1, 16'hFE06, 16'h0058, 0, 8'h00, 0, "ddr_58");
        access(0, 16'hFE04, 16'h0000, 0, 8'h00, 0, "dsr_busy");
        @(negedge clk);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        dv_m = 0;
        check("disp handshake", {15'b0, disp_valid}, 16'h0000);
        access(0, 16'hFE04, 16'h0000, 0, 8'h00, 0, "dsr_free");
        access(1, 16'hFE06, 16'h0041, 0, 8'h00, 0, "ddr_41");
        access(1, 16'hFE06, 16'h0042, 0, 8'h00, 0, "ddr_drop");
        access(1, 16'hFE06, 16'h0043, 0, 8'h00, 1, "ddr_handshake_wr");
        access(0, 16'hFE06, 16'h0000, 0, 8'h00, 0, "ddr_rd_zero");

        // Randomized mix against the model
        for (int i = 0; i < 16; i++) access(1, 16'h0200 + 16'(i), 16'(($urandom)), 0, 8'h00, 0, "pre_rand");
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            a = 16'h0200 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) kbd_pulse(8'($urandom));
            case (sel)
                0, 1, 2: access(1, a, 16'($urandom), $urandom_range(0, 3) == 0, 8'($urandom),
                                $urandom_range(0, 2) == 0, "rnd_wr");
                3, 4:    access(0, a, 16'h0000, $urandom_range(0, 3) == 0, 8'($urandom),
                                $urandom_range(0, 2) == 0, "rnd_rd");
                5:       access(0, 16'hFE00, 16'h0000, $urandom_range(0, 3) == 0, 8'($urandom),
                                $urandom_range(0, 2) == 0, "rnd_kbsr");
                6:       access(0, 16'hFE02, 16'h0000, $urandom_range(0, 3) == 0, 8'($urandom),
                                $urandom_range(0, 2) == 0, "rnd_kbdr");
                7:       access(0, 16'hFE04, 16'h0000, 0, 8'h00,
                                $urandom_range(0, 2) == 0, "rnd_dsr");
                8:       access(1, 16'hFE06, 16'($urandom), 0, 8'h00,
                                $urandom_range(0, 2) == 0, "rnd_ddr");
                default: access($urandom_range(0, 1) == 1, 16'hC000 + 16'($urandom_range(0, 16'h0FFF)),
                                16'($urandom), 0, 8'h00, 0, "rnd_unmapped");
            endcase
        end

        // Reset mid-access
        access(1, 16'h0020, 16'h0000, 0, 8'h00, 0, "pre_0020");
        @(negedge clk);
        mem_en = 1'b1; memwe = 1'b1; mar = 16'h0020; mdr = 16'h1234;
        @(posedge clk);
        #1 mem_en = 1'b0; memwe = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(mem_rdy);
        end
        check_reset_outputs("midreset");
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(mem_rdy);
        end
        check("midreset pulses", 16'(pulses), 16'h0000);
        access(0, 16'h0020, 16'h0000, 0, 8'h00, 0, "rd_0020_after_reset");
        access(0, 16'hFE00, 16'h0000, 0, 8'h00, 0, "kbsr_after_midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
